// File: rtl/sndbrd_pkg.sv
// -----------------------------------------------------------------------------
// sndbrd_pkg
// Shared types and constants for the sample-memory arbitration slice.
//   NUM_REQ      number of requesters sharing the sample memory port
//   ADDR_W_DEF   default memory address width
//   DATA_W_DEF   default sample data width
//   arb_state_t  arbiter FSM states (IDLE / OWN / GAP)
//   req_idx_t    requester index (2 bits)
//   idx2onehot   requester index -> one-hot requester vector
// -----------------------------------------------------------------------------
package sndbrd_pkg;

  localparam int NUM_REQ    = 4;
  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN  = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_t;

  typedef logic [1:0] req_idx_t;

  function automatic logic [NUM_REQ-1:0] idx2onehot(input req_idx_t idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/sample_mem_arbiter_rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
// Combinational round-robin picker for four requesters. Searches
// ptr+1, ptr+2, ptr+3, ptr (mod 4) and returns the first requester found.
// Ports:
//   req    in  [3:0]  pending requests
//   ptr    in  [1:0]  last winner (lowest priority in this search)
//   idx    out [1:0]  winning requester (valid when found=1)
//   found  out        at least one request pending
// -----------------------------------------------------------------------------
module rr_pick4
  import sndbrd_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           ptr,
  output req_idx_t           idx,
  output logic               found
);

  req_idx_t cand;

  // Walk the search order backwards so the nearest candidate after ptr
  // is the last one written and therefore wins.
  always_comb begin
    idx   = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ptr + req_idx_t'(k);
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sample_mem_arbiter.sv
// -----------------------------------------------------------------------------
// sample_mem_arbiter
// Round-robin arbiter sharing one sample memory port between 4 requesters
// (voices / recorder). One owner is granted at a time; the owner's accesses
// are registered onto the memory port and read-data-valid is routed back to
// the requester that issued the read, RD_LAT cycles after mem_en.
//
// Build option:
//   SNDBRD_ARB_REC_PRIO_EN  requester 0 (recorder) wins every arbitration it
//                           takes part in and is exempt from MAX_BURST;
//                           requesters 1-3 stay round-robin among themselves.
//
// Ports:
//   clock      in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   req        in   [3:0]        per-requester level request
//   we         in   [3:0]        per-requester write strobe (qualified by req)
//   addr_in    in   [4*ADDR_W]   requester i address at [i*ADDR_W +: ADDR_W]
//   wdata_in   in   [4*DATA_W]   requester i write data at [i*DATA_W +: DATA_W]
//   gnt        out  [3:0]        one-hot grant
//   mem_addr   out  [ADDR_W]     registered memory address
//   mem_we     out               registered memory write enable
//   mem_wdata  out  [DATA_W]     registered memory write data
//   mem_en     out               registered memory access strobe
//   mem_rdata  in   [DATA_W]     memory read data
//   rd_valid   out  [3:0]        one-hot: mem_rdata belongs to requester i
//   rd_data    out  [DATA_W]     mem_rdata passthrough
// -----------------------------------------------------------------------------
module sample_mem_arbiter
  import sndbrd_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 16,
  parameter int RD_LAT    = 2
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_in,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_en,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t        state, state_nxt;
  req_idx_t          ptr;        // last winner; while in OWN it is the current owner
  logic [CNT_W-1:0]  cnt;        // accesses accepted in the current grant
  logic [NUM_REQ-1:0] pick_req;
  req_idx_t          rr_idx, win_idx;
  logic              rr_found, win_found;
  logic              exempt;
  logic              accept, last_acc;
  req_idx_t          mem_idx_p0;
  logic              tag_vld_p [RD_LAT];
  req_idx_t          tag_idx_p [RD_LAT];

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = addr_in[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = wdata_in[i*DATA_W +: DATA_W];
  end

  rr_pick4 u_pick (
    .req   (pick_req),
    .ptr   (ptr),
    .idx   (rr_idx),
    .found (rr_found)
  );

`ifdef SNDBRD_ARB_REC_PRIO_EN
  // Recorder overrides the round-robin search, which then only covers 1-3.
  assign pick_req  = {req[NUM_REQ-1:1], 1'b0};
  assign win_idx   = req[0] ? req_idx_t'(0) : rr_idx;
  assign win_found = req[0] | rr_found;
  assign exempt    = (ptr == req_idx_t'(0));
`else
  assign pick_req  = req;
  assign win_idx   = rr_idx;
  assign win_found = rr_found;
  assign exempt    = 1'b0;
`endif

  assign accept   = (state == ARB_OWN) && req[ptr];
  assign last_acc = accept && (cnt == CNT_LAST) && !exempt;

  // State register and arbitration bookkeeping
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ARB_IDLE;
      ptr   <= req_idx_t'(NUM_REQ - 1);
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ARB_IDLE) && win_found) begin
        ptr <= win_idx;
        cnt <= '0;
      end else if (accept) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (win_found) state_nxt = ARB_OWN;
      ARB_OWN:  if (!req[ptr] || last_acc) state_nxt = ARB_GAP;
      ARB_GAP:  state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    if (state == ARB_OWN) gnt = idx2onehot(ptr);
  end

  // Stage p0: accepted access registered onto the memory port
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_idx_p0 <= '0;
    end else begin
      mem_en <= accept;
      mem_we <= accept && we[ptr];
      if (accept) begin
        mem_addr   <= addr_arr[ptr];
        mem_wdata  <= wdata_arr[ptr];
        mem_idx_p0 <= ptr;
      end
    end
  end

  // Stages p1..pRD_LAT: read tag follows the memory latency, so a read
  // returns to its issuer even if the grant has since moved on.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < RD_LAT; k++) begin
        tag_vld_p[k] <= 1'b0;
        tag_idx_p[k] <= '0;
      end
    end else begin
      tag_vld_p[0] <= mem_en && !mem_we;
      tag_idx_p[0] <= mem_idx_p0;
      for (int k = 1; k < RD_LAT; k++) begin
        tag_vld_p[k] <= tag_vld_p[k-1];
        tag_idx_p[k] <= tag_idx_p[k-1];
      end
    end
  end

  always_comb begin
    rd_valid = '0;
    if (tag_vld_p[RD_LAT-1]) rd_valid = idx2onehot(tag_idx_p[RD_LAT-1]);
  end

  assign rd_data = mem_rdata;

endmodule
